alu_op_sequencer: RTL

- Controller between the execute-stage issue logic and the single-cycle ALU; the ALU itself is instantiated outside this block.
- The ALU's shift ops move by exactly one bit per use. This block issues them repeatedly to implement a full SLL/SRL by shift amount 0-31.
- All other ALU ops are passed through as a single ALU cycle.
- Valid/ready request and response handshakes; busy drives the pipeline stall.

---
 rtl/alu_op_sequencer.sv | 123 ++++++++++++
 1 files changed

// File: rtl/alu_op_sequencer.sv
// Sequences ops onto an external single-cycle ALU. Full SLL/SRL are built from
// repeated one-bit ALU shifts. All other ops take a single ALU cycle.
module alu_op_sequencer #(
    parameter int DATA_W  = 32,
    parameter int SHAMT_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [3:0]        req_op,
    input  logic [DATA_W-1:0] req_a,
    input  logic [DATA_W-1:0] req_b,
    output logic [DATA_W-1:0] alu_in1,
    output logic [DATA_W-1:0] alu_in2,
    output logic [3:0]        alu_ctrl,
    input  logic [DATA_W-1:0] alu_result,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              busy
);

    localparam logic [3:0] OP_SLL = 4'd5;
    localparam logic [3:0] OP_SRL = 4'd6;

    typedef enum logic [1:0] {IDLE, EXEC, SHIFT, DONE} state_t;

    state_t              state_q;
    logic [3:0]          op_q;
    logic [DATA_W-1:0]   a_q;
    logic [DATA_W-1:0]   b_q;
    logic [DATA_W-1:0]   acc_q;
    logic [SHAMT_W-1:0]  cnt_q;
    logic [DATA_W-1:0]   rsp_data_q;

    logic [SHAMT_W-1:0]  req_shamt;
    logic                req_is_shift;
    logic                accept;

    assign req_shamt    = req_b[SHAMT_W-1:0];
    assign req_is_shift = (req_op == OP_SLL) || (req_op == OP_SRL);
    assign req_ready    = (state_q == IDLE) && !flush;
    assign accept       = req_valid && req_ready;

    assign rsp_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign rsp_data  = rsp_data_q;

    // ALU inputs are only non-zero while an ALU cycle is in flight.
    always_comb begin
        alu_in1  = '0;
        alu_in2  = '0;
        alu_ctrl = '0;
        case (state_q)
            EXEC: begin
                alu_in1  = a_q;
                alu_in2  = b_q;
                alu_ctrl = op_q;
            end
            SHIFT: begin
                alu_in1  = acc_q;
                alu_ctrl = op_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            op_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            rsp_data_q <= '0;
        end else if (flush) begin
            state_q <= IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        op_q <= req_op;
                        a_q  <= req_a;
                        b_q  <= req_b;
                        if (req_is_shift && (req_shamt == '0)) begin
                            rsp_data_q <= req_a;
                            state_q    <= DONE;
                        end else if (req_is_shift) begin
                            acc_q   <= req_a;
                            cnt_q   <= req_shamt;
                            state_q <= SHIFT;
                        end else begin
                            state_q <= EXEC;
                        end
                    end
                end
                EXEC: begin
                    rsp_data_q <= alu_result;
                    state_q    <= DONE;
                end
                SHIFT: begin
                    acc_q <= alu_result;
                    cnt_q <= cnt_q - 1'b1;
                    // Last one-bit step: its ALU output is the final result.
                    if (cnt_q == SHAMT_W'(1)) begin
                        rsp_data_q <= alu_result;
                        state_q    <= DONE;
                    end
                end
                DONE: begin
                    if (rsp_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
